// File: rtl/weight_bank_pkg.sv
// Shared types and helpers for the ping-pong convolution weight store.
package weight_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } wb_state_e;

  // Lane of (tap p, bank c) in the tap-major read word.
  function automatic int lane_idx(input int p, input int c, input int num_banks);
    return p * num_banks + c;
  endfunction

endpackage

// File: rtl/weight_bank_mem.sv
// One weight bank: both buffers in a single 1W1R array addressed {buf,row},
// followed by a valid-gated output pipe that holds its last word between reads.
module weight_bank_mem
  import weight_bank_pkg::*;
#(
  parameter int KPOS     = 9,
  parameter int DW       = 8,
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 3,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW:0]          waddr,
  input  logic [KPOS*DW-1:0]   wdata,
  input  logic [READ_LAT-2:0]  stage_vld,
  input  logic [AW:0]          raddr,
  output logic [KPOS*DW-1:0]   rdata
);

  localparam int WW       = KPOS * DW;
  localparam int NSTG     = READ_LAT - 1;
  localparam int MEM_ROWS = 2 ** (AW + 1);

  logic [WW-1:0] mem [MEM_ROWS];
  logic [WW-1:0] pipe_q [NSTG];
  logic [WW-1:0] pipe_d [NSTG];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Stage 0 is the URAM output register; each stage loads only when its input is valid.
  always_comb begin
    pipe_d[0] = stage_vld[0] ? mem[raddr] : pipe_q[0];
    for (int s = 1; s < NSTG; s++) begin
      pipe_d[s] = stage_vld[s] ? pipe_q[s-1] : pipe_q[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTG; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign rdata = pipe_q[NSTG-1];

endmodule

// File: rtl/weight_bank_pingpong.sv
// Double-buffered conv weight store: streaming loader fills the shadow buffer
// while the MAC array reads the active one; swap exchanges the two roles.
module weight_bank_pingpong
  import weight_bank_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int KPOS      = 9,
  parameter int DW        = 8,
  parameter int DEPTH     = 4096,
  parameter int READ_LAT  = 3,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ld_start,
  input  logic [AW:0]                     ld_count,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [KPOS*DW-1:0]              wr_data,
  output logic                            ld_done,
  output logic                            shadow_full,
  input  logic                            swap,
  output logic                            active_sel,
  input  logic                            rd_en,
  input  logic [AW-1:0]                   rd_addr,
  output logic                            rd_valid,
  output logic [NUM_BANKS*KPOS*DW-1:0]    rd_data
);

  localparam int WW = KPOS * DW;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  wb_state_e             state_q, state_d;
  logic                  active_sel_q, active_sel_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  ld_done_q, ld_done_d;
  logic                  shadow_full_q, shadow_full_d;
  logic [BW-1:0]         bank_ctr_q, bank_ctr_d;
  logic [AW-1:0]         row_ctr_q, row_ctr_d;
  logic [AW:0]           count_q, count_d;
  logic [READ_LAT-1:0]   vld_q, vld_d;
  logic [AW:0]           raddr_q, raddr_d;

  logic                  beat_s;
  logic                  last_beat_s;
  logic [AW:0]           wr_addr_s;
  logic [WW-1:0]         bank_rdata_s [NUM_BANKS];

  assign beat_s      = wr_valid & wr_ready_q;
  assign last_beat_s = beat_s && (bank_ctr_q == LAST_BANK) &&
                       ({1'b0, row_ctr_q} == (count_q - (AW + 1)'(1'b1)));
  assign wr_addr_s   = {~active_sel_q, row_ctr_q};

  // Loader FSM next state, load counters and read-pipe capture.
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    bank_ctr_d   = bank_ctr_q;
    row_ctr_d    = row_ctr_q;
    count_d      = count_q;
    ld_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start && (ld_count != '0)) begin
          count_d    = (ld_count > DEPTH_C) ? DEPTH_C : ld_count;
          bank_ctr_d = '0;
          row_ctr_d  = '0;
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (beat_s) begin
          if (bank_ctr_q == LAST_BANK) begin
            bank_ctr_d = '0;
            row_ctr_d  = row_ctr_q + AW'(1'b1);
          end else begin
            bank_ctr_d = bank_ctr_q + BW'(1'b1);
          end
          if (last_beat_s) begin
            ld_done_d = 1'b1;
            state_d   = FULL;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FULL: begin
        // swap wins over a simultaneous ld_start, which is simply dropped
        if (swap) begin
          active_sel_d = ~active_sel_q;
          state_d      = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wr_ready_d    = (state_d == LOAD);
    shadow_full_d = (state_d == FULL);
    vld_d         = {vld_q[READ_LAT-2:0], rd_en};
    raddr_d       = rd_en ? {active_sel_q, rd_addr} : raddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      active_sel_q  <= 1'b0;
      wr_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
      shadow_full_q <= 1'b0;
      bank_ctr_q    <= '0;
      row_ctr_q     <= '0;
      count_q       <= '0;
      vld_q         <= '0;
      raddr_q       <= '0;
    end else begin
      state_q       <= state_d;
      active_sel_q  <= active_sel_d;
      wr_ready_q    <= wr_ready_d;
      ld_done_q     <= ld_done_d;
      shadow_full_q <= shadow_full_d;
      bank_ctr_q    <= bank_ctr_d;
      row_ctr_q     <= row_ctr_d;
      count_q       <= count_d;
      vld_q         <= vld_d;
      raddr_q       <= raddr_d;
    end
  end

  for (genvar c = 0; c < NUM_BANKS; c++) begin : g_bank
    weight_bank_mem #(
      .KPOS     (KPOS),
      .DW       (DW),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT),
      .AW       (AW)
    ) u_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (beat_s && (bank_ctr_q == BW'(c))),
      .waddr     (wr_addr_s),
      .wdata     (wr_data),
      .stage_vld (vld_q[READ_LAT-2:0]),
      .raddr     (raddr_q),
      .rdata     (bank_rdata_s[c])
    );
    for (genvar p = 0; p < KPOS; p++) begin : g_tap
      assign rd_data[lane_idx(p, c, NUM_BANKS)*DW +: DW] = bank_rdata_s[c][p*DW +: DW];
    end
  end

  assign wr_ready    = wr_ready_q;
  assign ld_done     = ld_done_q;
  assign shadow_full = shadow_full_q;
  assign active_sel  = active_sel_q;
  assign rd_valid    = vld_q[READ_LAT-1];

endmodule
